// File: rtl/segre_csr_ctrl_if.sv
// ----------------------------------------------------------------------------
// segre_csr_ctrl_if
//
// Request/acknowledge bundle between the pipeline and the CSR sequencing
// controller (segre_csr_ctrl).
//
// Signals
//   exc_valid_i / exc_cause_i / exc_pc_i / exc_tval_i : exception request
//   exc_ack_o                                          : exception accepted
//   sret_valid_i / sret_ack_o                          : SRET request / accept
//   csr_wr_valid_i / csr_wr_addr_i / csr_wr_data_i     : pipeline CSR write
//   csr_wr_ready_o                                     : CSR write accepted
//
// Handshake rules, identical for all three channels:
//   - A requester raises *_valid_i and holds it, together with its payload,
//     until it sees the matching ack/ready high at the end of a cycle.
//   - The controller raises ack/ready for at most one channel per cycle.
//   - A transfer happens in a cycle where valid and ack/ready are both 1.
//   - ack/ready may depend combinationally on valid; valid never depends on
//     ack/ready.
//
// Modports
//   master : the pipeline side (drives requests)
//   slave  : the controller side (drives acks/ready)
//
// Widths are interface parameters so this file does not depend on
// segre_pkg compile order; the defaults match segre_pkg.
// ----------------------------------------------------------------------------
interface segre_csr_ctrl_if #(
    parameter int CSR_SIZE  = 12,
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 32
);
    logic                 exc_valid_i;
    logic [WORD_SIZE-1:0] exc_cause_i;
    logic [ADDR_SIZE-1:0] exc_pc_i;
    logic [ADDR_SIZE-1:0] exc_tval_i;
    logic                 exc_ack_o;

    logic                 sret_valid_i;
    logic                 sret_ack_o;

    logic                 csr_wr_valid_i;
    logic [CSR_SIZE-1:0]  csr_wr_addr_i;
    logic [WORD_SIZE-1:0] csr_wr_data_i;
    logic                 csr_wr_ready_o;

    modport master (
        output exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i,
        output sret_valid_i,
        output csr_wr_valid_i, csr_wr_addr_i, csr_wr_data_i,
        input  exc_ack_o, sret_ack_o, csr_wr_ready_o
    );

    modport slave (
        input  exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i,
        input  sret_valid_i,
        input  csr_wr_valid_i, csr_wr_addr_i, csr_wr_data_i,
        output exc_ack_o, sret_ack_o, csr_wr_ready_o
    );
endinterface

// File: rtl/segre_csr_ctrl.sv
// ----------------------------------------------------------------------------
// segre_pkg + segre_csr_ctrl
//
// segre_csr_ctrl is the single writer of the CSR file write port. In IDLE it
// forwards pipeline CSR writes with zero latency; on an exception or SRET it
// runs a fixed multi-cycle write sequence and then redirects the fetch PC for
// exactly one cycle.
//
// Parameters
//   ILL_CAUSE : scause value used when SRET is executed outside S-mode
//
// Ports
//   clk_i, rsn_i        : clock, asynchronous active-low reset
//   req (slave modport) : exception / SRET / CSR-write request channels
//   sie_i, priv_i       : current SIE bit and privilege level
//   sepc_i, stvec_i     : current SEPC / STVEC (redirect targets)
//   csr_we_o/_waddr_o/_wdata_o : CSR file write port
//   busy_o              : 1 in every state except IDLE
//   redirect_o/_pc_o    : one-cycle fetch redirect after a sequence
//   halt_o              : exception taken with SIE=0; only reset exits
//   tlb_flush_o         : pulse the cycle after a write to CSR_SATP
//   state_o             : current FSM state (debug)
//
// Configuration
//   SEGRE_CSR_CTRL_SATP_FLUSH_EN : when defined, tlb_flush_o is a registered
//   one-cycle pulse after every accepted write to CSR_SATP; otherwise it is
//   tied to 0 and no flush logic exists.
// ----------------------------------------------------------------------------
package segre_pkg;
    localparam int CSR_SIZE  = 12;
    localparam int WORD_SIZE = 32;
    localparam int ADDR_SIZE = 32;

    localparam logic [CSR_SIZE-1:0] CSR_SIE    = 12'h100;
    localparam logic [CSR_SIZE-1:0] CSR_SEPC   = 12'h141;
    localparam logic [CSR_SIZE-1:0] CSR_SCAUSE = 12'h142;
    localparam logic [CSR_SIZE-1:0] CSR_STVAL  = 12'h143;
    localparam logic [CSR_SIZE-1:0] CSR_SATP   = 12'h180;
    localparam logic [CSR_SIZE-1:0] CSR_PRIV   = 12'h7c0;

    localparam logic [WORD_SIZE-1:0] LOAD_ACCESS_FAULT = 32'd5;
endpackage

module segre_csr_ctrl
    import segre_pkg::*;
#(
    parameter logic [WORD_SIZE-1:0] ILL_CAUSE = 32'd2
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,

    segre_csr_ctrl_if.slave      req,

    input  logic                 sie_i,
    input  logic [WORD_SIZE-1:0] priv_i,
    input  logic [WORD_SIZE-1:0] sepc_i,
    input  logic [WORD_SIZE-1:0] stvec_i,

    output logic                 csr_we_o,
    output logic [CSR_SIZE-1:0]  csr_waddr_o,
    output logic [WORD_SIZE-1:0] csr_wdata_o,

    output logic                 busy_o,
    output logic                 redirect_o,
    output logic [ADDR_SIZE-1:0] redirect_pc_o,
    output logic                 halt_o,
    output logic                 tlb_flush_o,
    output logic [3:0]           state_o
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        T_SEPC  = 4'd1,
        T_CAUSE = 4'd2,
        T_TVAL  = 4'd3,
        T_PRIV  = 4'd4,
        T_SIE   = 4'd5,
        R_PRIV  = 4'd6,
        R_SIE   = 4'd7,
        REDIR   = 4'd8,
        HALT    = 4'd9
    } state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] cause_q, cause_d;
    logic [ADDR_SIZE-1:0] pc_q,    pc_d;
    logic [ADDR_SIZE-1:0] tval_q,  tval_d;
    // Selects the REDIR target: 1 = trap (stvec), 0 = SRET (sepc).
    logic                 trap_q,  trap_d;

    assign state_o = state_q;

    // ------------------------------------------------------------------
    // State and latched trap information
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q <= IDLE;
            cause_q <= '0;
            pc_q    <= '0;
            tval_q  <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            tval_q  <= tval_d;
            trap_q  <= trap_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d            = state_q;
        cause_d            = cause_q;
        pc_d               = pc_q;
        tval_d             = tval_q;
        trap_d             = trap_q;
        req.exc_ack_o      = 1'b0;
        req.sret_ack_o     = 1'b0;
        req.csr_wr_ready_o = 1'b0;
        csr_we_o           = 1'b0;
        csr_waddr_o        = '0;
        csr_wdata_o        = '0;
        busy_o             = 1'b1;
        redirect_o         = 1'b0;
        redirect_pc_o      = '0;
        halt_o             = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (req.exc_valid_i) begin
                    req.exc_ack_o = 1'b1;
                    cause_d       = req.exc_cause_i;
                    pc_d          = req.exc_pc_i;
                    tval_d        = req.exc_tval_i;
                    trap_d        = 1'b1;
                    state_d       = sie_i ? T_SEPC : HALT;
                end else if (req.sret_valid_i) begin
                    req.sret_ack_o = 1'b1;
                    if (priv_i == WORD_SIZE'(1)) begin
                        trap_d  = 1'b0;
                        state_d = R_PRIV;
                    end else begin
                        // SRET outside S-mode becomes an illegal-instruction
                        // trap with no faulting PC/value recorded.
                        cause_d = ILL_CAUSE;
                        pc_d    = '0;
                        tval_d  = '0;
                        trap_d  = 1'b1;
                        state_d = sie_i ? T_SEPC : HALT;
                    end
                end else begin
                    req.csr_wr_ready_o = 1'b1;
                    if (req.csr_wr_valid_i) begin
                        csr_we_o    = 1'b1;
                        csr_waddr_o = req.csr_wr_addr_i;
                        csr_wdata_o = req.csr_wr_data_i;
                    end
                end
            end
            T_SEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_SEPC;
                csr_wdata_o = WORD_SIZE'(pc_q);
                state_d     = T_CAUSE;
            end
            T_CAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_SCAUSE;
                csr_wdata_o = cause_q;
                state_d     = T_TVAL;
            end
            T_TVAL: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_STVAL;
                csr_wdata_o = WORD_SIZE'(tval_q);
                state_d     = T_PRIV;
            end
            T_PRIV: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_PRIV;
                csr_wdata_o = WORD_SIZE'(1);
                state_d     = T_SIE;
            end
            T_SIE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_SIE;
                csr_wdata_o = '0;
                state_d     = REDIR;
            end
            R_PRIV: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_PRIV;
                csr_wdata_o = '0;
                state_d     = R_SIE;
            end
            R_SIE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_SIE;
                csr_wdata_o = WORD_SIZE'(1);
                state_d     = REDIR;
            end
            REDIR: begin
                // Target is read live here so the just-written CSR file
                // values are what the fetch unit jumps to.
                redirect_o    = 1'b1;
                redirect_pc_o = trap_q ? ADDR_SIZE'(stvec_i) : ADDR_SIZE'(sepc_i);
                state_d       = IDLE;
            end
            HALT: begin
                halt_o = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // While reset is held the state is already IDLE, but IDLE would
        // otherwise show ready/acks; every output is forced low instead.
        if (!rsn_i) begin
            req.exc_ack_o      = 1'b0;
            req.sret_ack_o     = 1'b0;
            req.csr_wr_ready_o = 1'b0;
            csr_we_o           = 1'b0;
            csr_waddr_o        = '0;
            csr_wdata_o        = '0;
            busy_o             = 1'b0;
            redirect_o         = 1'b0;
            redirect_pc_o      = '0;
            halt_o             = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // TLB flush after a SATP write
    // ------------------------------------------------------------------
`ifdef SEGRE_CSR_CTRL_SATP_FLUSH_EN
    logic tlb_flush_q;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            tlb_flush_q <= 1'b0;
        end else begin
            tlb_flush_q <= csr_we_o && (csr_waddr_o == CSR_SATP);
        end
    end

    assign tlb_flush_o = tlb_flush_q;
`else
    assign tlb_flush_o = 1'b0;
`endif

endmodule

// File: tb/tb_segre_csr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_segre_csr_ctrl
//
// Self-checking bench for segre_csr_ctrl. A reference model builds the
// expected per-cycle output trace of each sequence from the architectural
// rules (which CSR gets which value, in which order, then one redirect),
// and each scenario task compares the DUT cycle by cycle against it.
// ----------------------------------------------------------------------------
module tb_segre_csr_ctrl;
    import segre_pkg::*;

    localparam int REC_W = 82;
`ifdef SEGRE_CSR_CTRL_SATP_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic        clk;
    logic        rst_n;
    logic        sie;
    logic [31:0] priv;
    logic [31:0] sepc;
    logic [31:0] stvec;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        busy_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        halt_o;
    logic        tlb_flush_o;
    logic [3:0]  state_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [REC_W-1:0] exp_q[$];

    segre_csr_ctrl_if bus ();

    segre_csr_ctrl dut (
        .clk_i         (clk),
        .rsn_i         (rst_n),
        .req           (bus),
        .sie_i         (sie),
        .priv_i        (priv),
        .sepc_i        (sepc),
        .stvec_i       (stvec),
        .csr_we_o      (csr_we_o),
        .csr_waddr_o   (csr_waddr_o),
        .csr_wdata_o   (csr_wdata_o),
        .busy_o        (busy_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .halt_o        (halt_o),
        .tlb_flush_o   (tlb_flush_o),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.exc_valid_i    = 1'b0;
        bus.exc_cause_i    = '0;
        bus.exc_pc_i       = '0;
        bus.exc_tval_i     = '0;
        bus.sret_valid_i   = 1'b0;
        bus.csr_wr_valid_i = 1'b0;
        bus.csr_wr_addr_i  = '0;
        bus.csr_wr_data_i  = '0;
    endtask

    // ------------------------------------------------------------------
    // Reference model: one record per cycle
    // {we, addr, data, redirect, redirect_pc, busy, exc_ack, sret_ack, ready}
    // ------------------------------------------------------------------
    function automatic logic [REC_W-1:0] rec(input logic we, input logic [11:0] a,
                                             input logic [31:0] d, input logic rd,
                                             input logic [31:0] rpc, input logic bsy,
                                             input logic ea, input logic sa,
                                             input logic rdy);
        return {we, a, d, rd, rpc, bsy, ea, sa, rdy};
    endfunction

    function automatic logic [REC_W-1:0] observe();
        return rec(csr_we_o, csr_waddr_o, csr_wdata_o, redirect_o, redirect_pc_o,
                   busy_o, bus.exc_ack_o, bus.sret_ack_o, bus.csr_wr_ready_o);
    endfunction

    // Trap entry: save pc, cause, tval; enter S-mode; mask interrupts; jump to stvec.
    function automatic void model_trap(input logic [31:0] cause, input logic [31:0] pc,
                                       input logic [31:0] tval, input logic [31:0] vec);
        exp_q.push_back(rec(1'b1, CSR_SEPC,   pc,    1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(rec(1'b1, CSR_SCAUSE, cause, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(rec(1'b1, CSR_STVAL,  tval,  1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(rec(1'b1, CSR_PRIV,   32'd1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(rec(1'b1, CSR_SIE,    32'd0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(rec(1'b0, '0, '0, 1'b1, vec, 1'b1, 1'b0, 1'b0, 1'b0));
    endfunction

    // Trap return: drop to U-mode, re-enable interrupts, jump to sepc.
    function automatic void model_sret(input logic [31:0] epc);
        exp_q.push_back(rec(1'b1, CSR_PRIV, 32'd0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(rec(1'b1, CSR_SIE,  32'd1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(rec(1'b0, '0, '0, 1'b1, epc, 1'b1, 1'b0, 1'b0, 1'b0));
    endfunction

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        clear_reqs();
        sie = 1'b1; priv = 32'd0; sepc = 32'h0; stvec = 32'h0;
        #12;
        n_tests++;
        if (bus.csr_wr_ready_o !== 1'b0 || busy_o !== 1'b0 || halt_o !== 1'b0 ||
            redirect_o !== 1'b0 || csr_we_o !== 1'b0 || tlb_flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%b busy=%b halt=%b redir=%b we=%b flush=%b exp all 0",
                     bus.csr_wr_ready_o, busy_o, halt_o, redirect_o, csr_we_o, tlb_flush_o);
        end
        bus.exc_valid_i = 1'b1; bus.csr_wr_valid_i = 1'b1; bus.csr_wr_addr_i = CSR_SATP;
        #1;
        n_tests++;
        if (bus.exc_ack_o !== 1'b0 || csr_we_o !== 1'b0 || csr_waddr_o !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_reqs_ignored got ack=%b we=%b addr=%h exp 0 0 000",
                     bus.exc_ack_o, csr_we_o, csr_waddr_o);
        end
        clear_reqs();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.csr_wr_ready_o !== 1'b1 || busy_o !== 1'b0 || state_o !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_release got rdy=%b busy=%b state=%0d exp 1 0 0",
                     bus.csr_wr_ready_o, busy_o, state_o);
        end
    endtask

    task automatic test_trap();
        logic [31:0] cause, pc, tval, vec;
        logic [REC_W-1:0] got, exp;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                cause = LOAD_ACCESS_FAULT; pc = 32'h100; tval = 32'h8004; vec = 32'h2000;
            end else begin
                cause = $urandom; pc = $urandom; tval = $urandom; vec = $urandom;
            end
            tick();
            sie = 1'b1; stvec = vec;
            bus.exc_valid_i = 1'b1; bus.exc_cause_i = cause;
            bus.exc_pc_i = pc; bus.exc_tval_i = tval;
            @(negedge clk);
            n_tests++;
            if (bus.exc_ack_o !== 1'b1 || bus.csr_wr_ready_o !== 1'b0 || csr_we_o !== 1'b0) begin
                n_fail++;
                $display("FAIL trap_ack[%0d] got ack=%b rdy=%b we=%b exp 1 0 0",
                         i, bus.exc_ack_o, bus.csr_wr_ready_o, csr_we_o);
            end
            model_trap(cause, pc, tval, vec);
            tick();
            // Payload is only valid while requesting; scramble it to prove latching.
            bus.exc_valid_i = 1'b0; bus.exc_cause_i = $urandom;
            bus.exc_pc_i = $urandom; bus.exc_tval_i = $urandom;
            for (int k = 1; exp_q.size() > 0; k++) begin
                @(negedge clk);
                exp = exp_q.pop_front();
                got = observe();
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL trap_seq[%0d] cycle N+%0d got %h exp %h", i, k, got, exp);
                end
            end
            @(negedge clk);
            n_tests++;
            if (busy_o !== 1'b0 || bus.csr_wr_ready_o !== 1'b1 || redirect_o !== 1'b0) begin
                n_fail++;
                $display("FAIL trap_idle[%0d] got busy=%b rdy=%b redir=%b exp 0 1 0",
                         i, busy_o, bus.csr_wr_ready_o, redirect_o);
            end
        end
    endtask

    task automatic test_sret();
        logic [REC_W-1:0] got, exp;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                priv = 32'd1; sepc = 32'h100;
            end else if (i == 1) begin
                priv = 32'd0; sepc = $urandom;
            end else begin
                priv = ($urandom_range(0, 2) == 0) ? 32'd3 : 32'd1;
                sepc = $urandom;
            end
            tick();
            sie = 1'b1; stvec = $urandom;
            bus.sret_valid_i = 1'b1;
            @(negedge clk);
            n_tests++;
            if (bus.sret_ack_o !== 1'b1 || bus.exc_ack_o !== 1'b0 || bus.csr_wr_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL sret_ack[%0d] got sack=%b eack=%b rdy=%b exp 1 0 0",
                         i, bus.sret_ack_o, bus.exc_ack_o, bus.csr_wr_ready_o);
            end
            if (priv == 32'd1) model_sret(sepc);
            else               model_trap(32'd2, 32'd0, 32'd0, stvec);
            tick();
            bus.sret_valid_i = 1'b0;
            for (int k = 1; exp_q.size() > 0; k++) begin
                @(negedge clk);
                exp = exp_q.pop_front();
                got = observe();
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL sret_seq[%0d] priv=%0d cycle N+%0d got %h exp %h",
                             i, priv, k, got, exp);
                end
            end
            @(negedge clk);
            n_tests++;
            if (busy_o !== 1'b0 || redirect_o !== 1'b0) begin
                n_fail++;
                $display("FAIL sret_idle[%0d] got busy=%b redir=%b exp 0 0", i, busy_o, redirect_o);
            end
        end
    endtask

    task automatic test_priority();
        logic [REC_W-1:0] got, exp;
        logic [11:0] waddr;
        logic [31:0] wdata;
        waddr = 12'h5a0; wdata = $urandom;
        tick();
        sie = 1'b1; priv = 32'd1; sepc = 32'h300; stvec = 32'h2000;
        bus.exc_valid_i = 1'b1; bus.exc_cause_i = LOAD_ACCESS_FAULT;
        bus.exc_pc_i = 32'h40; bus.exc_tval_i = 32'h44;
        bus.sret_valid_i = 1'b1;
        bus.csr_wr_valid_i = 1'b1; bus.csr_wr_addr_i = waddr; bus.csr_wr_data_i = wdata;
        @(negedge clk);
        n_tests++;
        if (bus.exc_ack_o !== 1'b1 || bus.sret_ack_o !== 1'b0 ||
            bus.csr_wr_ready_o !== 1'b0 || csr_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_N got eack=%b sack=%b rdy=%b we=%b exp 1 0 0 0",
                     bus.exc_ack_o, bus.sret_ack_o, bus.csr_wr_ready_o, csr_we_o);
        end
        model_trap(LOAD_ACCESS_FAULT, 32'h40, 32'h44, 32'h2000);
        tick();
        bus.exc_valid_i = 1'b0;
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            got = observe();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL prio_trap cycle N+%0d got %h exp %h", k, got, exp);
            end
        end
        @(negedge clk);
        n_tests++;
        if (bus.sret_ack_o !== 1'b1 || bus.csr_wr_ready_o !== 1'b0 || csr_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_sret_N+7 got sack=%b rdy=%b we=%b exp 1 0 0",
                     bus.sret_ack_o, bus.csr_wr_ready_o, csr_we_o);
        end
        model_sret(32'h300);
        tick();
        bus.sret_valid_i = 1'b0;
        for (int k = 8; exp_q.size() > 0; k++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            got = observe();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL prio_sret cycle N+%0d got %h exp %h", k, got, exp);
            end
        end
        @(negedge clk);
        n_tests++;
        if (bus.csr_wr_ready_o !== 1'b1 || csr_we_o !== 1'b1 ||
            csr_waddr_o !== waddr || csr_wdata_o !== wdata) begin
            n_fail++;
            $display("FAIL prio_write got rdy=%b we=%b addr=%h data=%h exp 1 1 %h %h",
                     bus.csr_wr_ready_o, csr_we_o, csr_waddr_o, csr_wdata_o, waddr, wdata);
        end
        tick();
        clear_reqs();
    endtask

    task automatic test_csr_write();
        logic [11:0] a;
        logic [31:0] d;
        logic prev_satp;
        prev_satp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0 || i == 4) begin
                a = CSR_SATP; d = 32'h8000;
            end else if ($urandom_range(0, 3) == 0) begin
                a = CSR_SATP; d = $urandom;
            end else begin
                a = 12'($urandom_range(0, 4095));
                if (a == CSR_SATP) a = 12'h001;
                d = $urandom;
            end
            tick();
            bus.csr_wr_valid_i = 1'b1; bus.csr_wr_addr_i = a; bus.csr_wr_data_i = d;
            @(negedge clk);
            n_tests++;
            if (bus.csr_wr_ready_o !== 1'b1 || csr_we_o !== 1'b1 || csr_waddr_o !== a ||
                csr_wdata_o !== d || busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_fwd[%0d] got rdy=%b we=%b addr=%h data=%h busy=%b exp 1 1 %h %h 0",
                         i, bus.csr_wr_ready_o, csr_we_o, csr_waddr_o, csr_wdata_o, busy_o, a, d);
            end
            n_tests++;
            if (tlb_flush_o !== (FLUSH_EN && prev_satp)) begin
                n_fail++;
                $display("FAIL wr_flush[%0d] got %b exp %b", i, tlb_flush_o, FLUSH_EN && prev_satp);
            end
            prev_satp = (a == CSR_SATP);
        end
        tick();
        clear_reqs();
        @(negedge clk);
        n_tests++;
        if (csr_we_o !== 1'b0 || csr_waddr_o !== 12'h0 || csr_wdata_o !== 32'h0 ||
            tlb_flush_o !== (FLUSH_EN && prev_satp)) begin
            n_fail++;
            $display("FAIL wr_idle got we=%b addr=%h data=%h flush=%b exp 0 000 00000000 %b",
                     csr_we_o, csr_waddr_o, csr_wdata_o, tlb_flush_o, FLUSH_EN && prev_satp);
        end
        @(negedge clk);
        n_tests++;
        if (tlb_flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_flush_pulse_end got %b exp 0", tlb_flush_o);
        end
    endtask

    task automatic test_halt();
        for (int i = 0; i < 2; i++) begin
            tick();
            sie = 1'b0; priv = 32'd0;
            if (i == 0) begin
                bus.exc_valid_i = 1'b1; bus.exc_cause_i = $urandom;
            end else begin
                bus.sret_valid_i = 1'b1;
            end
            @(negedge clk);
            n_tests++;
            if ((bus.exc_ack_o | bus.sret_ack_o) !== 1'b1 || halt_o !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_ack[%0d] got ack=%b halt=%b exp 1 0",
                         i, bus.exc_ack_o | bus.sret_ack_o, halt_o);
            end
            tick();
            clear_reqs();
            // Any new request is held off forever.
            bus.sret_valid_i = 1'b1; bus.csr_wr_valid_i = 1'b1; bus.csr_wr_addr_i = CSR_SATP;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                n_tests++;
                if (halt_o !== 1'b1 || busy_o !== 1'b1 || csr_we_o !== 1'b0 || redirect_o !== 1'b0 ||
                    bus.sret_ack_o !== 1'b0 || bus.csr_wr_ready_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL halt_hold[%0d] N+%0d got halt=%b busy=%b we=%b redir=%b sack=%b rdy=%b exp 1 1 0 0 0 0",
                             i, k, halt_o, busy_o, csr_we_o, redirect_o, bus.sret_ack_o, bus.csr_wr_ready_o);
                end
            end
            tick();
            rst_n = 1'b0;
            #1;
            n_tests++;
            if (halt_o !== 1'b0 || busy_o !== 1'b0 || bus.sret_ack_o !== 1'b0 || state_o !== 4'd0) begin
                n_fail++;
                $display("FAIL halt_reset[%0d] got halt=%b busy=%b sack=%b state=%0d exp 0 0 0 0",
                         i, halt_o, busy_o, bus.sret_ack_o, state_o);
            end
            clear_reqs();
            tick();
            rst_n = 1'b1;
            @(negedge clk);
            n_tests++;
            if (halt_o !== 1'b0 || bus.csr_wr_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL halt_release[%0d] got halt=%b rdy=%b exp 0 1", i, halt_o, bus.csr_wr_ready_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        int redirects;
        tick();
        sie = 1'b1; stvec = 32'h2000;
        bus.exc_valid_i = 1'b1; bus.exc_cause_i = LOAD_ACCESS_FAULT;
        bus.exc_pc_i = 32'h100; bus.exc_tval_i = 32'h8004;
        tick();
        clear_reqs();
        tick();
        tick();
        n_tests++;
        if (csr_we_o !== 1'b1 || csr_waddr_o !== CSR_STVAL) begin
            n_fail++;
            $display("FAIL mid_pre got we=%b addr=%h exp 1 %h", csr_we_o, csr_waddr_o, CSR_STVAL);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (csr_we_o !== 1'b0 || redirect_o !== 1'b0 || busy_o !== 1'b0 || state_o !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset got we=%b redir=%b busy=%b state=%0d exp 0 0 0 0",
                     csr_we_o, redirect_o, busy_o, state_o);
        end
        tick();
        rst_n = 1'b1;
        redirects = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (redirect_o === 1'b1 || csr_we_o === 1'b1 || busy_o === 1'b1) redirects++;
        end
        n_tests++;
        if (redirects !== 0) begin
            n_fail++;
            $display("FAIL mid_after got %0d active cycles exp 0", redirects);
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence and report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_trap();
        test_sret();
        test_priority();
        test_csr_write();
        test_halt();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
